two_bit_adder: RTL and testbench
================================

// Module: two_bit_adder
// PURPOSE
//  Unsigned 2-bit adder with a 3-bit result. SUM is purely combinational.
//  A registered copy of the sum and a saturating carry-event counter serve
//  downstream pipelined logic and status/debug readout.
//  Leaf arithmetic block in the datapath; no handshake with neighbours.
// PARAMETERS
//  CNT_W    8    width of CARRY_CNT; counter saturates at 2**CNT_W-1
// PORTS
//  clk        in   1      single clock; all state updates on its rising edge
//  rst        in   1      asynchronous reset, active-high
//  A          in   2      addend, unsigned
//  B          in   2      addend, unsigned
//  SUM        out  3      combinational A+B; SUM[2] is the carry-out
//  SUM_Q      out  3      SUM registered on the rising edge of clk
//  CARRY_CNT  out  CNT_W  count of clk edges where SUM[2]=1, saturating
// BEHAVIOUR
//  - SUM = {1'b0,A} + {1'b0,B}, full 3-bit result; no truncation or wrap.
//    Range 0..6. Built as a ripple carry chain:
//    - Bit 0 is a half adder: s0=A0^B0, c0=A0&B0.
//    - Bit 1 is a full adder: s1=A1^B1^c0, c1=A1&B1 | c0&(A1^B1).
//    - SUM={c1,s1,s0}.
//  - SUM depends only on A and B. It settles within the same timestep as an
//    input change, with no clock edge required.
//  - SUM stays correct while clk is idle or floating, and while rst is
//    asserted or floating.
//  - SUM_Q has 1-cycle latency: on each rising clk edge, SUM_Q <= SUM.
//  - CARRY_CNT on each rising clk edge:
//    - if SUM[2]=1 and CARRY_CNT < max, CARRY_CNT <= CARRY_CNT+1;
//    - at max it holds (saturates, never wraps);
//    - otherwise it holds its value.
//  - Reset: rst=1 immediately forces SUM_Q=3'b000 and CARRY_CNT=0.
//    - Both are held while rst=1.
//    - They resume updating on the first rising clk edge after rst falls.
//    - Reset mid-operation discards the count, with no partial update.
//    - SUM is unaffected by rst.
//  - X/Z on A or B may produce X on SUM. No internal masking is required.
//  - No other state, no FSM, no handshake, no enable.
// TESTING
//  1. Exhaustive combinational check: all 16 (A,B) pairs.
//     - Settle 1 ns, then SUM must equal A+B exactly (!==).
//     - Examples: 00+00 -> 000; 01+10 -> 011; 11+01 -> 100; 11+11 -> 110.
//     - Run with clk/rst tied low and again with them left unconnected.
//  2. Registered path: rst pulse, then A=2'b10, B=2'b11.
//     - SUM=101 immediately.
//     - SUM_Q=000 until the next rising edge, then 101.
//  3. Carry count: A=11, B=01 held for 5 edges -> CARRY_CNT=5.
//     Then A=01, B=01 for 3 edges -> CARRY_CNT stays 5.
//  4. Saturation: CNT_W=2, carry held for 6 edges -> CARRY_CNT 1,2,3,3,3,3.
//  5. Async reset mid-count: assert rst between edges when CARRY_CNT=4.
//     - SUM_Q and CARRY_CNT go to 0 without waiting for a clk edge.
//     - SUM still equals A+B during reset.
//     - After release, counting restarts from 0.

Source files
------------

// File: rtl/two_bit_adder_if.sv
// Bus bundle for the 2-bit adder.
//   A, B       : 2-bit unsigned addends (driven by master)
//   SUM        : combinational 3-bit sum, SUM[2] is carry-out
//   SUM_Q      : SUM registered on the rising clock edge
//   CARRY_CNT  : saturating count of clock edges with carry-out set
interface two_bit_adder_if #(
    parameter int unsigned CNT_W = 8
);
    logic [1:0]       A;
    logic [1:0]       B;
    logic [2:0]       SUM;
    logic [2:0]       SUM_Q;
    logic [CNT_W-1:0] CARRY_CNT;

    modport master (
        output A,
        output B,
        input  SUM,
        input  SUM_Q,
        input  CARRY_CNT
    );

    modport slave (
        input  A,
        input  B,
        output SUM,
        output SUM_Q,
        output CARRY_CNT
    );
endinterface

// File: rtl/two_bit_adder.sv
// Unsigned 2-bit ripple-carry adder with a registered sum and a saturating
// carry-event counter.
//   clk  : rising-edge clock for SUM_Q and CARRY_CNT
//   rst  : asynchronous active-high reset of SUM_Q and CARRY_CNT
//   bus  : slave side of two_bit_adder_if (A, B in; SUM, SUM_Q, CARRY_CNT out)
module two_bit_adder #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    two_bit_adder_if.slave   bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s0;
    logic             c0;
    logic             s1;
    logic             c1;
    logic [2:0]       sum_q;
    logic [CNT_W-1:0] carry_cnt;

    // Ripple chain: half adder on bit 0, full adder on bit 1.
    always_comb begin
        s0 = bus.A[0] ^ bus.B[0];
        c0 = bus.A[0] & bus.B[0];
        s1 = bus.A[1] ^ bus.B[1] ^ c0;
        c1 = (bus.A[1] & bus.B[1]) | (c0 & (bus.A[1] ^ bus.B[1]));
    end

    assign bus.SUM = {c1, s1, s0};

    // Registered sum and carry-event counter; the counter holds at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q     <= 3'b000;
            carry_cnt <= '0;
        end else begin
            sum_q <= {c1, s1, s0};
            if (c1 && (carry_cnt != CNT_MAX)) begin
                carry_cnt <= carry_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.SUM_Q     = sum_q;
    assign bus.CARRY_CNT = carry_cnt;
endmodule

// File: tb/tb_two_bit_adder.sv
// Scoreboard bench for two_bit_adder: one instance with an 8-bit counter and
// one with a 2-bit counter to reach saturation quickly.
module tb_two_bit_adder;
    logic clk;
    logic rst;
    logic clk_en;

    two_bit_adder_if #(.CNT_W(8)) bus8 ();
    two_bit_adder_if #(.CNT_W(2)) bus2 ();

    two_bit_adder #(.CNT_W(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    two_bit_adder #(.CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    // Clock stays low until enabled so the combinational path can be checked idle.
    initial begin
        clk = 1'b0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    typedef enum int unsigned {
        SEL_SUM, SEL_SUM_Q, SEL_CNT8, SEL_CNT2
    } sel_e;

    typedef struct {
        string      name;
        sel_e       sel;
        logic [7:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Monitor: pops each expectation and compares against the live outputs.
    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            wait (exp_q.size() != 0);
            e = exp_q.pop_front();
            case (e.sel)
                SEL_SUM:   act = {5'b0, bus8.SUM};
                SEL_SUM_Q: act = {5'b0, bus8.SUM_Q};
                SEL_CNT8:  act = bus8.CARRY_CNT;
                default:   act = {6'b0, bus2.CARRY_CNT};
            endcase
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s: got %0d (%b) expected %0d (%b) at %0t",
                         e.name, act, act, e.exp, e.exp, $time);
            end
        end
    end

    task automatic expect_val(input string name, input sel_e sel, input logic [7:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        exp_q.push_back(e);
    endtask

    task automatic set_ab(input logic [1:0] a, input logic [1:0] b);
        bus8.A = a;
        bus8.B = b;
        bus2.A = a;
        bus2.B = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        #1;
        expect_val("rst_sum_q", SEL_SUM_Q, 8'd0);
        expect_val("rst_cnt8",  SEL_CNT8,  8'd0);
        expect_val("rst_cnt2",  SEL_CNT2,  8'd0);
        #1;
        rst = 1'b0;
    endtask

    // Directed exhaustive table: index {A,B} -> hand-computed sum.
    logic [2:0] sum_tbl [16] = '{
        3'd0, 3'd1, 3'd2, 3'd3,
        3'd1, 3'd2, 3'd3, 3'd4,
        3'd2, 3'd3, 3'd4, 3'd5,
        3'd3, 3'd4, 3'd5, 3'd6
    };

    logic [1:0] cnt2_seq [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

    initial begin
        clk_en = 1'b0;
        rst    = 1'b0;
        set_ab(2'b00, 2'b00);

        // Initial reset with clock idle.
        #2;
        rst = 1'b1;
        #1;
        expect_val("init_sum_q", SEL_SUM_Q, 8'd0);
        expect_val("init_cnt8",  SEL_CNT8,  8'd0);
        expect_val("init_cnt2",  SEL_CNT2,  8'd0);
        #1;

        // Exhaustive combinational sum, with reset held and then released.
        for (int pass = 0; pass < 2; pass++) begin
            rst = (pass == 0);
            for (int i = 0; i < 16; i++) begin
                logic [3:0] ab;
                ab = 4'(i);
                set_ab(ab[3:2], ab[1:0]);
                #1;
                expect_val($sformatf("comb_sum_a%0d_b%0d_rst%0d", ab[3:2], ab[1:0], pass),
                           SEL_SUM, {5'b0, sum_tbl[i]});
                #1;
            end
        end
        expect_val("idle_sum_q", SEL_SUM_Q, 8'd0);
        expect_val("idle_cnt8",  SEL_CNT8,  8'd0);

        // Registered path: SUM immediate, SUM_Q after one edge.
        rst = 1'b1;
        #1;
        set_ab(2'b10, 2'b11);
        #1;
        expect_val("reg_sum_now", SEL_SUM, 8'd5);
        rst = 1'b0;
        #1;
        expect_val("reg_sum_q_before", SEL_SUM_Q, 8'd0);
        #1;
        clk_en = 1'b1;
        tick();
        expect_val("reg_sum_q_after", SEL_SUM_Q, 8'd5);

        // Carry count: 5 carry edges then 3 non-carry edges.
        reset_pulse();
        set_ab(2'b11, 2'b01);
        for (int i = 1; i <= 5; i++) begin
            tick();
            expect_val($sformatf("cnt_carry_%0d", i), SEL_CNT8, 8'(i));
        end
        expect_val("cnt_sum_q_carry", SEL_SUM_Q, 8'd4);
        set_ab(2'b01, 2'b01);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_val($sformatf("cnt_hold_%0d", i), SEL_CNT8, 8'd5);
        end
        expect_val("cnt_sum_q_nocarry", SEL_SUM_Q, 8'd2);

        // Saturation on the 2-bit counter; 8-bit counter keeps counting.
        reset_pulse();
        set_ab(2'b11, 2'b11);
        for (int i = 0; i < 6; i++) begin
            tick();
            expect_val($sformatf("sat_cnt2_%0d", i), SEL_CNT2, {6'b0, cnt2_seq[i]});
            expect_val($sformatf("sat_cnt8_%0d", i), SEL_CNT8, 8'(i + 1));
        end

        // Asynchronous reset mid-count.
        reset_pulse();
        set_ab(2'b10, 2'b10);
        for (int i = 0; i < 4; i++) tick();
        expect_val("mid_cnt_before", SEL_CNT8, 8'd4);
        #2;
        rst = 1'b1;
        #1;
        expect_val("mid_rst_sum_q", SEL_SUM_Q, 8'd0);
        expect_val("mid_rst_cnt8",  SEL_CNT8,  8'd0);
        expect_val("mid_rst_sum",   SEL_SUM,   8'd4);
        tick();
        expect_val("mid_hold_cnt8",  SEL_CNT8,  8'd0);
        expect_val("mid_hold_sum_q", SEL_SUM_Q, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        expect_val("mid_restart_cnt8",  SEL_CNT8,  8'd1);
        expect_val("mid_restart_sum_q", SEL_SUM_Q, 8'd4);

        // Drain the scoreboard with a bounded wait.
        #5;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
